// File: rtl/spi_gpio_expander.sv
// rtl/spi_gpio_expander.sv - SPI-addressable output expander with static and 8-bit PWM pins
module spi_gpio_expander #(
  parameter int NUM_PINS = 7,
  parameter int PWM_DIV  = 1
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                ss,
  input  logic                sclk,
  input  logic                mosi,
  output logic                miso,
  output logic [NUM_PINS-1:0] chip_out,
  output logic                wr_pulse
);
  localparam int NB = (NUM_PINS + 7) / 8;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state, state_nxt;

  logic [1:0] ss_sync, sclk_sync, mosi_sync;
  logic       sclk_d;
  logic       ss_q, sclk_q, mosi_q, rise, fall;

  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte;
  logic [7:0] tx_shift;
  logic       miso_r;
  logic       rw;
  logic [6:0] addr;
  logic       byte_done, cmd_done, data_done, wr_en, rd_load;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;

  logic [NUM_PINS-1:0] out_reg, mode_reg, pwm;
  logic [7:0]          duty     [NUM_PINS];
  logic [7:0]          duty_act [NUM_PINS];
  logic [15:0]         presc;
  logic [7:0]          cnt;
  logic                tick;

  // Two-flop synchronisers; ss idles high so it resets to 1.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      ss_sync   <= 2'b11;
      sclk_sync <= 2'b00;
      mosi_sync <= 2'b00;
      sclk_d    <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[0], ss};
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      sclk_d    <= sclk_sync[1];
    end
  end

  assign ss_q    = ss_sync[1];
  assign sclk_q  = sclk_sync[1];
  assign mosi_q  = mosi_sync[1];
  assign rise    = sclk_q & ~sclk_d;
  assign fall    = ~sclk_q & sclk_d;
  assign rx_byte = {rx_shift, mosi_q};

  assign byte_done = ~ss_q & rise & (bit_cnt == 3'd7);
  assign cmd_done  = byte_done & (state == CMD);
  assign data_done = byte_done & (state == DATA);
  assign wr_en     = data_done & ~rw;
  assign rd_load   = (cmd_done & rx_byte[7]) | (data_done & rw);
  assign rd_addr   = cmd_done ? rx_byte[6:0] : addr + 7'd1;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!ss_q) state_nxt = CMD;
      CMD:     if (byte_done) state_nxt = DATA;
      DATA:    state_nxt = DATA;
      default: state_nxt = IDLE;
    endcase
    if (ss_q) state_nxt = IDLE;
  end

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (i / 8 == int'(rd_addr))      rd_data[3'(i % 8)] = out_reg[i];
      if (i / 8 + 16 == int'(rd_addr)) rd_data[3'(i % 8)] = mode_reg[i];
      if (i + 32 == int'(rd_addr))     rd_data = duty[i];
    end
    if (rd_addr == 7'h7f) rd_data = 8'(NUM_PINS);
  end

  // Shift engine: rx on synced rising sclk, tx on synced falling sclk.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      bit_cnt  <= 3'd0;
      rx_shift <= 7'd0;
      tx_shift <= 8'd0;
      miso_r   <= 1'b0;
      rw       <= 1'b0;
      addr     <= 7'd0;
      wr_pulse <= 1'b0;
    end else begin
      wr_pulse <= wr_en;
      if (ss_q) begin
        bit_cnt  <= 3'd0;
        tx_shift <= 8'd0;
        miso_r   <= 1'b0;
      end else begin
        if (rise) begin
          bit_cnt  <= bit_cnt + 3'd1;
          rx_shift <= rx_byte[6:0];
        end
        if (cmd_done) begin
          rw   <= rx_byte[7];
          addr <= rx_byte[6:0];
        end
        if (data_done) addr <= addr + 7'd1;
        if (fall) begin
          miso_r   <= tx_shift[7];
          tx_shift <= {tx_shift[6:0], 1'b0};
        end
        if (rd_load) tx_shift <= rd_data;
      end
    end
  end

  assign miso = miso_r & ~ss;

  // Register file; bytes or bits with no backing pin simply have no flop.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      out_reg  <= '0;
      mode_reg <= '0;
      for (int i = 0; i < NUM_PINS; i++) duty[i] <= 8'd0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_PINS; i++) begin
        if (i / 8 == int'(addr))      out_reg[i]  <= rx_byte[3'(i % 8)];
        if (i / 8 + 16 == int'(addr)) mode_reg[i] <= rx_byte[3'(i % 8)];
        if (i + 32 == int'(addr))     duty[i]     <= rx_byte;
      end
    end
  end

  assign tick = (presc == 16'(PWM_DIV - 1));

  // duty_act only reloads on the wrap to 0, so a period never sees a mid-cycle duty change.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      presc <= 16'd0;
      cnt   <= 8'd0;
      for (int i = 0; i < NUM_PINS; i++) duty_act[i] <= 8'd0;
    end else if (tick) begin
      presc <= 16'd0;
      cnt   <= cnt + 8'd1;
      if (cnt == 8'hff)
        for (int i = 0; i < NUM_PINS; i++) duty_act[i] <= duty[i];
    end else begin
      presc <= presc + 16'd1;
    end
  end

  always_comb begin
    pwm = '0;
    for (int i = 0; i < NUM_PINS; i++) pwm[i] = (cnt < duty_act[i]);
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) chip_out <= '0;
    else      chip_out <= (mode_reg & pwm) | (~mode_reg & out_reg);
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, NB[0]};
endmodule
